reduce_eject_arbiter: RTL



---
 rtl/node_pkg.sv | 41 ++++
 rtl/reduce_chan_fifo.sv | 68 ++++++
 rtl/reduce_eject_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Shared node constants: flit field positions and widths used by the router,
// this ejection front end and the reduce unit.
package node_pkg;

    localparam int            LG_NUMPROCS_DEFAULT   = 3;
    localparam int            PAYLOAD_WIDTH_DEFAULT = 32;
    localparam logic [1:0]    REDUCE_ALG_DEFAULT    = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int alg_type_pos(input int payload_width);
        return payload_width + 4;
    endfunction

    function automatic int valid_bit_pos(input int payload_width);
        return payload_width + 49;
    endfunction

    function automatic int flit_width(input int payload_width);
        return payload_width + 50;
    endfunction

    function automatic int flit_child_width(input int payload_width, input int lg_np);
        return flit_width(payload_width) + lg_np;
    endfunction

    function automatic int port_width(input int num_ports);
        return (clog2(num_ports) < 1) ? 1 : clog2(num_ports);
    endfunction

    localparam int AlgTypePos     = alg_type_pos(PAYLOAD_WIDTH_DEFAULT);
    localparam int ValidBitPos    = valid_bit_pos(PAYLOAD_WIDTH_DEFAULT);
    localparam int FlitWidth      = flit_width(PAYLOAD_WIDTH_DEFAULT);
    localparam int FlitChildWidth = flit_child_width(PAYLOAD_WIDTH_DEFAULT, LG_NUMPROCS_DEFAULT);

endpackage

// File: rtl/reduce_chan_fifo.sv
// Single-clock FIFO for one eject channel; DEPTH must be a power of two so the
// pointers wrap naturally.
module reduce_chan_fifo
    import node_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push_eff, pop_eff;

    assign pop_eff  = pop && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_eff = push && (!full_q || pop_eff);

    always_comb begin
        wr_ptr_d = push_eff ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_eff  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/reduce_eject_arbiter.sv
// Collective-reduce ejection front end: filters reduce flits per eject channel,
// buffers them, and round-robin drains them into one registered valid/ready stream.
module reduce_eject_arbiter
    import node_pkg::*;
#(
    parameter int         lg_numprocs  = LG_NUMPROCS_DEFAULT,
    parameter int         PayloadWidth = PAYLOAD_WIDTH_DEFAULT,
    parameter int         NUM_PORTS    = 6,
    parameter int         DEPTH        = 4,
    parameter logic [1:0] REDUCE_ALG   = REDUCE_ALG_DEFAULT,
    localparam int        FCW          = flit_child_width(PayloadWidth, lg_numprocs),
    localparam int        PortW        = port_width(NUM_PORTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PORTS*FCW-1:0] eject_in,
    output logic [FCW-1:0]           out_flit,
    output logic [PortW-1:0]         out_port,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_PORTS-1:0]     chan_full,
    output logic [NUM_PORTS-1:0]     overflow,
    output logic [NUM_PORTS*16-1:0]  drop_count
);

    localparam int AlgPos = alg_type_pos(PayloadWidth);
    localparam int VbPos  = valid_bit_pos(PayloadWidth);
    localparam int CW     = clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0] fifo_empty, fifo_full, push_req, push_ok, pop;
    logic [FCW-1:0]       fifo_dout  [NUM_PORTS];
    logic [CW-1:0]        fifo_count [NUM_PORTS];

    logic                 out_valid_q, out_valid_d;
    logic [FCW-1:0]       out_flit_q, out_flit_d;
    logic [PortW-1:0]     out_port_q, out_port_d;
    logic [PortW-1:0]     last_grant_q, last_grant_d;
    logic                 load, found;
    logic [PortW-1:0]     grant, cand;
    int                   idx;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
        logic [FCW-1:0] flit;
        logic [15:0]    drop_cnt_q, drop_cnt_d;
        logic           ovf_q, ovf_d;
        logic           drop;

        assign flit        = eject_in[p*FCW +: FCW];
        assign push_req[p] = flit[VbPos] && (flit[AlgPos +: 2] == REDUCE_ALG);
        assign push_ok[p]  = push_req[p] && ((fifo_count[p] < CW'(DEPTH)) || pop[p]);
        assign drop        = push_req[p] && !push_ok[p];

        reduce_chan_fifo #(
            .WIDTH (FCW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_ok[p]),
            .push_data (flit),
            .pop       (pop[p]),
            .pop_data  (fifo_dout[p]),
            .count     (fifo_count[p]),
            .full      (fifo_full[p]),
            .empty     (fifo_empty[p])
        );

        always_comb begin
            drop_cnt_d = drop_cnt_q;
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
            ovf_d = ovf_q | drop;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                drop_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else begin
                drop_cnt_q <= drop_cnt_d;
                ovf_q      <= ovf_d;
            end
        end

        assign drop_count[p*16 +: 16] = drop_cnt_q;
        assign overflow[p]            = ovf_q;
    end

    assign load = !out_valid_q || out_ready;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        found = 1'b0;
        grant = last_grant_q;
        idx   = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PortW'(idx);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        pop          = '0;
        out_valid_d  = out_valid_q;
        out_flit_d   = out_flit_q;
        out_port_d   = out_port_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (found) begin
                pop[grant]   = 1'b1;
                out_valid_d  = 1'b1;
                out_flit_d   = fifo_dout[grant];
                out_port_d   = grant;
                last_grant_d = grant;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            out_port_q   <= '0;
            last_grant_q <= PortW'(NUM_PORTS - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
            out_port_q   <= out_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_port  = out_port_q;
    assign chan_full = fifo_full;

endmodule
